// File: rtl/crs_pkg.sv
// crs_pkg: shared definitions for the challenge/response sequencer.
//   crs_state_e : sequencer state encoding
//   nb_bytes()  : number of UART bytes needed to carry a given bit width
//   cnt_width() : register width for a counter that must hold 0..n-1
package crs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RX     = 3'd1,
        ST_RUN    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_TX     = 3'd4,
        ST_TXWAIT = 3'd5
    } crs_state_e;

    function automatic int nb_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

    // Never narrower than one bit, so degenerate counters still elaborate.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/majority_vote_acc.sv
// majority_vote_acc: one vote counter per response bit.
//   clk, Rst_n : clock, async active-low reset
//   clr_i      : zero all counters
//   acc_i      : add resp_i[i] to counter i
//   resp_i     : engine response being accumulated
//   voted_o    : bit i set when counter i holds a strict majority of REPS
module majority_vote_acc
    import crs_pkg::*;
#(
    parameter int unsigned RESP_BITS = 8,
    parameter int unsigned REPS      = 1
) (
    input  logic                 clk,
    input  logic                 Rst_n,
    input  logic                 clr_i,
    input  logic                 acc_i,
    input  logic [RESP_BITS-1:0] resp_i,
    output logic [RESP_BITS-1:0] voted_o
);

    localparam int VW = cnt_width(REPS + 1);
    localparam logic [VW-1:0] HALF = VW'(REPS / 2);

    logic [VW-1:0] vote_q [RESP_BITS];

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < RESP_BITS; i++) vote_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < RESP_BITS; i++) vote_q[i] <= '0;
        end else if (acc_i) begin
            for (int i = 0; i < RESP_BITS; i++) vote_q[i] <= vote_q[i] + VW'(resp_i[i]);
        end
    end

    // REPS is odd, so "more than half" can never tie.
    always_comb begin
        voted_o = '0;
        for (int i = 0; i < RESP_BITS; i++) voted_o[i] = (vote_q[i] > HALF);
    end

endmodule

// File: rtl/challenge_response_sequencer.sv
// challenge_response_sequencer: sits between the UART and the response engine.
// Collects a CHAL_BITS challenge (LSB byte first), runs the engine REPS times
// with per-bit majority voting, then returns the RESP_BITS result LSB byte first.
//   clk, Rst_n          : clock, async active-low reset
//   RxDone, RxData      : received byte strobe and data
//   TxDone              : transmitter finished current byte
//   eng_done, eng_resp  : engine completion strobe and response
//   RxEn                : receiver enable
//   TxEn, TxData        : transmit start pulse and byte
//   eng_start, Triger   : engine start pulse (Triger mirrors it for the scope)
//   challenge           : assembled challenge
//   busy                : not idle
//   err                 : one-cycle pulse on receive or engine timeout
//
// state   | meaning
// IDLE    | receiver enabled, waiting for first challenge byte
// RX      | collecting remaining challenge bytes, inter-byte timer running
// RUN     | one-cycle engine start
// WAIT    | waiting for eng_done, engine timer running
// TX      | load voted byte, pulse TxEn
// TXWAIT  | waiting for TxDone
module challenge_response_sequencer
    import crs_pkg::*;
#(
    parameter int unsigned CHAL_BITS   = 16,
    parameter int unsigned RESP_BITS   = 8,
    parameter int unsigned REPS        = 1,
    parameter int unsigned TIMEOUT_CYC = 4000000
) (
    input  logic                 clk,
    input  logic                 Rst_n,
    input  logic                 RxDone,
    input  logic [7:0]           RxData,
    input  logic                 TxDone,
    input  logic                 eng_done,
    input  logic [RESP_BITS-1:0] eng_resp,
    output logic                 RxEn,
    output logic                 TxEn,
    output logic [7:0]           TxData,
    output logic                 eng_start,
    output logic [CHAL_BITS-1:0] challenge,
    output logic                 Triger,
    output logic                 busy,
    output logic                 err
);

    localparam int NB_RX = nb_bytes(CHAL_BITS);
    localparam int NB_TX = nb_bytes(RESP_BITS);
    localparam int CW    = NB_RX * 8;
    localparam int TXW   = NB_TX * 8;
    localparam int BC_W  = cnt_width(NB_RX + 1);
    localparam int TC_W  = cnt_width(NB_TX + 1);
    localparam int RC_W  = cnt_width(REPS + 1);
    localparam int TM_W  = cnt_width(TIMEOUT_CYC);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB_RX - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(NB_TX - 1);
    localparam logic [RC_W-1:0] RC_REPS = RC_W'(REPS);
    localparam logic [TM_W-1:0] TM_LOAD = TM_W'(TIMEOUT_CYC - 1);

    crs_state_e           state_q;
    logic [BC_W-1:0]      byte_cnt_q;
    logic [TC_W-1:0]      tx_cnt_q;
    logic [RC_W-1:0]      rep_cnt_q;
    logic [TM_W-1:0]      timer_q;
    logic [CHAL_BITS-1:0] chal_q;
    logic [CHAL_BITS-1:0] chal_d;
    logic                 rx_en_q;
    logic                 tx_en_q;
    logic [7:0]           tx_data_q;
    logic                 eng_start_q;
    logic                 busy_q;
    logic                 err_q;

    logic [RESP_BITS-1:0] voted;
    logic [TXW-1:0]       voted_wide;
    logic [7:0]           tx_byte;
    logic [CW-1:0]        chal_wide;
    int                   chal_idx;
    logic                 vote_clr;
    logic                 vote_acc;

    assign vote_clr = (state_q == ST_IDLE);
    assign vote_acc = (state_q == ST_WAIT) && eng_done;

    majority_vote_acc #(
        .RESP_BITS (RESP_BITS),
        .REPS      (REPS)
    ) u_vote (
        .clk     (clk),
        .Rst_n   (Rst_n),
        .clr_i   (vote_clr),
        .acc_i   (vote_acc),
        .resp_i  (eng_resp),
        .voted_o (voted)
    );

    // The first byte of a frame starts from an all-zero word so nothing from
    // an earlier or abandoned frame leaks into the upper bytes. byte_cnt_q may
    // still hold the previous frame's count in the first IDLE cycle, hence the
    // explicit index override.
    always_comb begin
        chal_idx  = (state_q == ST_IDLE) ? 0 : int'(byte_cnt_q);
        chal_wide = (state_q == ST_IDLE) ? '0 : CW'(chal_q);
        for (int b = 0; b < NB_RX; b++) begin
            if (chal_idx == b) chal_wide[8*b +: 8] = RxData;
        end
        chal_d = chal_wide[CHAL_BITS-1:0];
    end

    assign voted_wide = TXW'(voted);

    always_comb begin
        tx_byte = '0;
        for (int b = 0; b < NB_TX; b++) begin
            if (int'(tx_cnt_q) == b) tx_byte = voted_wide[8*b +: 8];
        end
    end

    // Outputs are registered on the transition into the state that owns them,
    // so eng_start is high during RUN and TxEn is high during the first TXWAIT cycle.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            tx_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            timer_q     <= '0;
            chal_q      <= '0;
            rx_en_q     <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_en_q     <= 1'b0;
            eng_start_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rx_en_q    <= 1'b1;
                    byte_cnt_q <= '0;
                    tx_cnt_q   <= '0;
                    rep_cnt_q  <= '0;
                    timer_q    <= TM_LOAD;
                    if (RxDone) begin
                        chal_q     <= chal_d;
                        byte_cnt_q <= BC_W'(1);
                        busy_q     <= 1'b1;
                        if (NB_RX == 1) begin
                            rx_en_q     <= 1'b0;
                            eng_start_q <= 1'b1;
                            state_q     <= ST_RUN;
                        end else begin
                            state_q <= ST_RX;
                        end
                    end
                end

                ST_RX: begin
                    if (RxDone) begin
                        chal_q     <= chal_d;
                        timer_q    <= TM_LOAD;
                        byte_cnt_q <= byte_cnt_q + BC_W'(1);
                        if (byte_cnt_q == BC_LAST) begin
                            rx_en_q     <= 1'b0;
                            eng_start_q <= 1'b1;
                            state_q     <= ST_RUN;
                        end
                    end else if (timer_q == '0) begin
                        err_q   <= 1'b1;
                        chal_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q - TM_W'(1);
                    end
                end

                ST_RUN: begin
                    rep_cnt_q <= rep_cnt_q + RC_W'(1);
                    timer_q   <= TM_LOAD;
                    state_q   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (eng_done) begin
                        if (rep_cnt_q < RC_REPS) begin
                            eng_start_q <= 1'b1;
                            state_q     <= ST_RUN;
                        end else begin
                            state_q <= ST_TX;
                        end
                    end else if (timer_q == '0) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        rx_en_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q - TM_W'(1);
                    end
                end

                ST_TX: begin
                    tx_data_q <= tx_byte;
                    tx_en_q   <= 1'b1;
                    state_q   <= ST_TXWAIT;
                end

                ST_TXWAIT: begin
                    if (TxDone) begin
                        if (tx_cnt_q == TC_LAST) begin
                            busy_q  <= 1'b0;
                            rx_en_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + TC_W'(1);
                            state_q  <= ST_TX;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign RxEn      = rx_en_q;
    assign TxEn      = tx_en_q;
    assign TxData    = tx_data_q;
    assign eng_start = eng_start_q;
    assign Triger    = eng_start_q;
    assign challenge = chal_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_challenge_response_sequencer.sv
module tb_challenge_response_sequencer;

    localparam int CHAL_BITS = 16;
    localparam int RESP_BITS = 12;
    localparam int REPS      = 3;
    localparam int TMO       = 100;

    logic                 clk = 1'b0;
    logic                 Rst_n;
    logic                 RxDone;
    logic [7:0]           RxData;
    logic                 TxDone;
    logic                 eng_done;
    logic [RESP_BITS-1:0] eng_resp;
    logic                 RxEn;
    logic                 TxEn;
    logic [7:0]           TxData;
    logic                 eng_start;
    logic [CHAL_BITS-1:0] challenge;
    logic                 Triger;
    logic                 busy;
    logic                 err;

    int errs    = 0;
    int checks  = 0;
    int n_start = 0;
    int n_txen  = 0;
    int n_err   = 0;

    challenge_response_sequencer #(
        .CHAL_BITS   (CHAL_BITS),
        .RESP_BITS   (RESP_BITS),
        .REPS        (REPS),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .RxDone    (RxDone),
        .RxData    (RxData),
        .TxDone    (TxDone),
        .eng_done  (eng_done),
        .eng_resp  (eng_resp),
        .RxEn      (RxEn),
        .TxEn      (TxEn),
        .TxData    (TxData),
        .eng_start (eng_start),
        .challenge (challenge),
        .Triger    (Triger),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (eng_start === 1'b1) n_start++;
        if (TxEn === 1'b1)      n_txen++;
        if (err === 1'b1)       n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RxDone = 1'b1;
        RxData = b;
        tick();
        RxDone = 1'b0;
    endtask

    // Random strobes on inputs the current state must ignore.
    task automatic noise_tick(input bit rx, input bit eng, input bit tx);
        RxDone   = rx  & 1'($urandom_range(0, 1));
        eng_done = eng & 1'($urandom_range(0, 1));
        TxDone   = tx  & 1'($urandom_range(0, 1));
        RxData   = 8'($urandom);
        eng_resp = RESP_BITS'($urandom);
        tick();
        RxDone   = 1'b0;
        eng_done = 1'b0;
        TxDone   = 1'b0;
    endtask

    // Bit i of the answer is set when most of the evaluations returned 1 there.
    function automatic logic [RESP_BITS-1:0] model_vote(input logic [RESP_BITS-1:0] a,
                                                        input logic [RESP_BITS-1:0] b,
                                                        input logic [RESP_BITS-1:0] c);
        logic [RESP_BITS-1:0] v;
        int ones;
        v = '0;
        for (int i = 0; i < RESP_BITS; i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            v[i] = (ones > REPS / 2);
        end
        return v;
    endfunction

    // One complete frame: 2 challenge bytes, REPS engine runs, 2 response bytes.
    // eng_gap = 0 picks a random engine delay per run.
    task automatic run_frame(input logic [15:0] chal,
                             input logic [RESP_BITS-1:0] r0,
                             input logic [RESP_BITS-1:0] r1,
                             input logic [RESP_BITS-1:0] r2,
                             input int rx_gap,
                             input int eng_gap);
        logic [RESP_BITS-1:0] rs [3];
        logic [15:0]          word;
        int                   s0, t0, e0, gap, ngap;
        rs[0] = r0;
        rs[1] = r1;
        rs[2] = r2;
        word  = 16'(model_vote(r0, r1, r2));
        s0 = n_start;
        t0 = n_txen;
        e0 = n_err;

        chk("idle_busy", busy, 0);
        chk("idle_rxen", RxEn, 1);
        send_byte(chal[7:0]);
        chk("rx_busy", busy, 1);
        chk("rx_start_early", eng_start, 0);
        for (int g = 0; g < rx_gap; g++) noise_tick(1'b0, 1'b1, 1'b1);
        send_byte(chal[15:8]);
        chk("start_latency", eng_start, 1);
        chk("triger", Triger, 1);
        chk("run_rxen", RxEn, 0);
        chk("challenge", challenge, 32'(chal));

        for (int r = 0; r < REPS; r++) begin
            gap = (eng_gap > 0) ? eng_gap : int'($urandom_range(1, 8));
            for (int g = 0; g < gap; g++) noise_tick(1'b1, 1'b0, 1'b1);
            eng_done = 1'b1;
            eng_resp = rs[r];
            tick();
            eng_done = 1'b0;
            eng_resp = RESP_BITS'($urandom);
            if (r < REPS - 1) begin
                chk("rerun_start", eng_start, 1);
            end else begin
                chk("tx_early", TxEn, 0);
                tick();
            end
        end

        for (int k = 0; k < 2; k++) begin
            chk("tx_en", TxEn, 1);
            chk("tx_data", 32'(TxData), 32'((word >> (8 * k)) & 16'h00FF));
            chk("tx_challenge", 32'(challenge), 32'(chal));
            ngap = int'($urandom_range(0, 4));
            for (int g = 0; g < ngap; g++) noise_tick(1'b1, 1'b1, 1'b0);
            TxDone = 1'b1;
            tick();
            TxDone = 1'b0;
            if (k == 0) tick();
        end

        chk("done_busy", busy, 0);
        chk("done_rxen", RxEn, 1);
        chk("n_start", n_start - s0, REPS);
        chk("n_txen", n_txen - t0, 2);
        chk("n_err", n_err - e0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, s0, t0, e0;
        Rst_n    = 1'b0;
        RxDone   = 1'b0;
        RxData   = '0;
        TxDone   = 1'b0;
        eng_done = 1'b0;
        eng_resp = '0;
        repeat (3) tick();

        chk("rst_rxen", RxEn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txen", TxEn, 0);
        chk("rst_txdata", TxData, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_chal", challenge, 0);
        chk("rst_err", err, 0);
        Rst_n = 1'b1;
        chk("rxen_before_clock", RxEn, 0);
        tick();
        chk("rxen_rise", RxEn, 1);

        // Directed frames
        run_frame(16'h1234, 12'hABC, 12'hABC, 12'hABC, 2, 0);
        run_frame(16'hBEEF, 12'h0F0, 12'h0CC, 12'h0AA, 0, 0);
        // RxDone on the very cycle the inter-byte timer expires must win
        run_frame(16'hC0DE, 12'h5A5, 12'hFFF, 12'h000, TMO - 1, 0);
        // Engine answers one cycle before its timer would expire
        run_frame(16'h0F0F, 12'h123, 12'h321, 12'h111, 1, TMO - 1);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            run_frame(16'($urandom), RESP_BITS'($urandom), RESP_BITS'($urandom),
                      RESP_BITS'($urandom), int'($urandom_range(0, 6)), 0);
        end

        // Receive timeout: one byte, then silence
        s0 = n_start;
        e0 = n_err;
        send_byte(8'h34);
        n = 0;
        while (err !== 1'b1 && n < 3 * TMO) begin
            tick();
            n++;
        end
        chk("rx_to_cycles", n, TMO);
        chk("rx_to_busy", busy, 0);
        chk("rx_to_rxen", RxEn, 1);
        tick();
        chk("rx_to_err_pulse", err, 0);
        chk("rx_to_nstart", n_start - s0, 0);
        chk("rx_to_nerr", n_err - e0, 1);
        run_frame(16'h5678, 12'h9C3, 12'h9C3, 12'h1C2, 0, 0);

        // Engine timeout: eng_done withheld. WAIT starts one cycle after the
        // eng_start cycle, and the timer then allows TMO cycles.
        t0 = n_txen;
        e0 = n_err;
        send_byte(8'h11);
        send_byte(8'h22);
        chk("eto_start", eng_start, 1);
        n = 0;
        while (err !== 1'b1 && n < 3 * TMO) begin
            tick();
            n++;
        end
        chk("eng_to_cycles", n, TMO + 1);
        chk("eng_to_busy", busy, 0);
        chk("eng_to_rxen", RxEn, 1);
        tick();
        chk("eng_to_err_pulse", err, 0);
        chk("eng_to_ntxen", n_txen - t0, 0);
        chk("eng_to_nerr", n_err - e0, 1);

        // Reset while the first response byte is in flight
        send_byte(8'hC3);
        send_byte(8'h5A);
        for (int r = 0; r < REPS; r++) begin
            tick();
            eng_done = 1'b1;
            eng_resp = RESP_BITS'($urandom);
            tick();
            eng_done = 1'b0;
        end
        tick();
        chk("pre_rst_txen", TxEn, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_txen", TxEn, 0);
        chk("arst_busy", busy, 0);
        chk("arst_chal", challenge, 0);
        chk("arst_rxen", RxEn, 0);
        tick();
        Rst_n = 1'b1;
        chk("arst_hold_rxen", RxEn, 0);
        tick();
        chk("arst_rxen_rise", RxEn, 1);
        run_frame(16'($urandom), RESP_BITS'($urandom), RESP_BITS'($urandom),
                  RESP_BITS'($urandom), 3, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/challenge_response_sequencer.md
Name: challenge_response_sequencer

Overview:
- Parametrised successor to the single-shot UART control FSM.
- Collects a multi-byte challenge from the UART receiver and drives the response engine through a start/done handshake, optionally repeated with per-bit majority voting.
- Serialises a multi-byte response back through the UART transmitter.
- Sits between UART_top and the response engine (AND/arbiter core); replaces the fixed-width receive/transmit shift-register control.

Parameters:
- CHAL_BITS, 16: challenge width. Received LSB byte first; NB_RX = ceil(CHAL_BITS/8) bytes.
- RESP_BITS, 8: response width. Sent LSB byte first; NB_TX = ceil(RESP_BITS/8) bytes.
- REPS, 1: engine evaluations per challenge. Must be odd, 1..15.
- TIMEOUT_CYC, 4000000: cycles allowed between RxDone pulses, and from eng_start to eng_done.

Ports:
- clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- RxDone  in  1  one-cycle pulse; byte valid on RxData.
- RxData  in  8  received byte.
- TxDone  in  1  one-cycle pulse; transmitter finished the current byte.
- eng_done  in  1  one-cycle pulse; eng_resp valid.
- eng_resp  in  RESP_BITS  engine response.
- RxEn  out  1  receiver enable.
- TxEn  out  1  one-cycle pulse; start transmitting TxData.
- TxData  out  8  byte to transmit.
- eng_start  out  1  one-cycle pulse; start the engine.
- challenge  out  CHAL_BITS  assembled challenge; stable from RUN until return to IDLE.
- Triger  out  1  copy of eng_start, for the scope header.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all outputs and registers are registered and reset to 0; state IDLE. RxEn rises on the first clock after Rst_n deasserts.
- IDLE:
  - RxEn=1; vote counters, byte counter, rep counter and timer cleared.
  - On RxDone: RxData goes to challenge[7:0], byte_cnt=1. Next state is RUN if NB_RX==1, else RX.
- RX:
  - RxEn=1. Each RxDone writes byte byte_cnt at bits [8*byte_cnt +: 8], masked to CHAL_BITS, and clears the timer.
  - After the NB_RX-th byte: RxEn=0, next state RUN.
  - If the timer reaches TIMEOUT_CYC-1 without RxDone: err pulse, go to IDLE, partial challenge discarded.
  - RxDone and timer expiry in the same cycle: RxDone wins.
- RUN: eng_start=Triger=1 for exactly one cycle; rep_cnt increments; timer cleared; go to WAIT.
- WAIT:
  - On eng_done, each vote counter i adds eng_resp[i].
  - If rep_cnt<REPS, go to RUN on the next cycle; otherwise go to TX.
  - Timer expiry before eng_done: err pulse, go to IDLE, no TxEn.
- Voted result: bit i = (vote_cnt[i] > REPS/2). With REPS=1 this equals eng_resp.
- TX: TxData = voted byte tx_cnt, with bits above RESP_BITS zero-filled; TxEn pulses for one cycle; go to TXWAIT.
- TXWAIT: on TxDone, tx_cnt++. If tx_cnt==NB_TX go to IDLE, else go to TX.
- Latency:
  - Last RxDone to eng_start: 1 cycle.
  - Final eng_done to first TxEn: 2 cycles.
- Ignored events: RxDone outside IDLE/RX, eng_done outside WAIT, TxDone outside TXWAIT.
- Reset mid-operation: immediate return to the reset values; no partial frame survives.

Decomposition:
- Package crs_pkg holds:
  - state encoding (IDLE, RX, RUN, WAIT, TX, TXWAIT);
  - functions for NB_RX, NB_TX and counter widths (clog2 of NB_RX+1, REPS+1, TIMEOUT_CYC).
- One sub-module, majority_vote_acc: RESP_BITS counters with clear, accumulate-enable and voted-output logic, parametrised by RESP_BITS and REPS.

Test Plan:
- Defaults: RxData 0x34 then 0x12 -> challenge=0x1234, one eng_start one cycle after the second RxDone, busy=1. Return eng_resp 0xA5 -> TxEn with TxData=0xA5. TxDone -> IDLE, busy=0.
- REPS=3, RESP_BITS=8: eng_resp 0xF0, 0xCC, 0xAA on successive eng_done -> exactly 3 eng_start pulses, then TxData=0xE8.
- RESP_BITS=12: eng_resp 0xABC -> TxData 0xBC, then after TxDone a second TxEn with TxData 0x0A -> IDLE.
- Rx timeout (TIMEOUT_CYC=100): send 0x34, then idle 100 cycles -> err pulse, IDLE, no eng_start. Then send 0x78, 0x56 -> challenge=0x5678.
- Engine timeout (TIMEOUT_CYC=100): eng_done withheld for 100 cycles after eng_start -> err pulse, IDLE, no TxEn.
- Rst_n low during TXWAIT -> TxEn, busy, challenge go to 0 asynchronously. After release, RxEn=1 next clock and a new frame completes normally.
